fa_cla: RTL and testbench

- Bit-slice full-adder cell for carry-lookahead adders.
- Each slice produces sum, ripple carry-out, propagate (P) and generate (G).
- External lookahead logic consumes P/G to form the carry into each slice; slices are never chained internally.
- Optional output register stage plus slice-group P/G, so the block can serve as the leaf of a pipelined CLA.

---
 rtl/fa_cla.sv | 109 ++++++++++
 tb/tb_fa_cla.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fa_cla.sv
// fa_cla: bit-slice full-adder cells for use as the leaf of a carry-lookahead adder.
// Every slice is independent; the carry into each slice comes from external
// lookahead logic. Slice P/G are also reduced into group P/G, so a higher
// lookahead level can treat this block as a single wide slice.
module fa_cla #(
  parameter int WIDTH   = 1,
  parameter int REG_OUT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] cin,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  output logic [WIDTH-1:0] s,
  output logic [WIDTH-1:0] cout,
  output logic [WIDTH-1:0] p,
  output logic [WIDTH-1:0] g,
  output logic             gp,
  output logic             gg
);

  logic [WIDTH-1:0] p_c;
  logic [WIDTH-1:0] g_c;
  logic [WIDTH-1:0] s_c;
  logic [WIDTH-1:0] cout_c;
  logic             gp_c;
  logic             gg_c;

  // Slice add and group P/G; gg folds from slice 0 upward so higher slices dominate.
  always_comb begin
    p_c    = a ^ b;
    g_c    = a & b;
    s_c    = p_c ^ cin;
    cout_c = g_c | (p_c & cin);
    gp_c   = &p_c;
    gg_c   = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      gg_c = g_c[i] | (p_c[i] & gg_c);
    end
  end

  if (REG_OUT != 0) begin : g_reg
    logic [WIDTH-1:0] s_q, s_d;
    logic [WIDTH-1:0] cout_q, cout_d;
    logic [WIDTH-1:0] p_q, p_d;
    logic [WIDTH-1:0] g_q, g_d;
    logic             gp_q, gp_d;
    logic             gg_q, gg_d;
    logic             vld_q;

    // Load new results only on qualified cycles so unqualified inputs never reach the outputs.
    always_comb begin
      s_d    = s_q;
      cout_d = cout_q;
      p_d    = p_q;
      g_d    = g_q;
      gp_d   = gp_q;
      gg_d   = gg_q;
      if (in_valid) begin
        s_d    = s_c;
        cout_d = cout_c;
        p_d    = p_c;
        g_d    = g_c;
        gp_d   = gp_c;
        gg_d   = gg_c;
      end
    end

    // Output register stage; reset clears everything, including the valid flag.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        s_q    <= '0;
        cout_q <= '0;
        p_q    <= '0;
        g_q    <= '0;
        gp_q   <= 1'b0;
        gg_q   <= 1'b0;
        vld_q  <= 1'b0;
      end else begin
        s_q    <= s_d;
        cout_q <= cout_d;
        p_q    <= p_d;
        g_q    <= g_d;
        gp_q   <= gp_d;
        gg_q   <= gg_d;
        vld_q  <= in_valid;
      end
    end

    assign s         = s_q;
    assign cout      = cout_q;
    assign p         = p_q;
    assign g         = g_q;
    assign gp        = gp_q;
    assign gg        = gg_q;
    assign out_valid = vld_q;
  end else begin : g_comb
    assign s         = s_c;
    assign cout      = cout_c;
    assign p         = p_c;
    assign g         = g_c;
    assign gp        = gp_c;
    assign gg        = gg_c;
    assign out_valid = in_valid;
  end

endmodule

// File: tb/tb_fa_cla.sv
// Bench for fa_cla: registered 1-, 4- and 8-slice instances plus a
// combinational 1-slice instance, checked against an arithmetic model.
module tb_fa_cla;

  logic clk;
  logic rst_n;

  logic       vld1, cin1, a1, b1;
  logic       ov1, s1, co1, p1, g1, gp1, gg1;

  logic       vld4;
  logic [3:0] cin4, a4, b4;
  logic       ov4;
  logic [3:0] s4, co4, p4, g4;
  logic       gp4, gg4;

  logic       vld8;
  logic [7:0] cin8, a8, b8;
  logic       ov8;
  logic [7:0] s8, co8, p8, g8;
  logic       gp8, gg8;

  logic       vld0, cin0, a0, b0;
  logic       ov0, s0, co0, p0, g0, gp0, gg0;

  int total;
  int bad;

  fa_cla #(.WIDTH(1), .REG_OUT(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(vld1), .cin(cin1), .a(a1), .b(b1),
    .out_valid(ov1), .s(s1), .cout(co1), .p(p1), .g(g1), .gp(gp1), .gg(gg1));

  fa_cla #(.WIDTH(4), .REG_OUT(1)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(vld4), .cin(cin4), .a(a4), .b(b4),
    .out_valid(ov4), .s(s4), .cout(co4), .p(p4), .g(g4), .gp(gp4), .gg(gg4));

  fa_cla #(.WIDTH(8), .REG_OUT(1)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(vld8), .cin(cin8), .a(a8), .b(b8),
    .out_valid(ov8), .s(s8), .cout(co8), .p(p8), .g(g8), .gp(gp8), .gg(gg8));

  fa_cla #(.WIDTH(1), .REG_OUT(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(vld0), .cin(cin0), .a(a0), .b(b0),
    .out_valid(ov0), .s(s0), .cout(co0), .p(p0), .g(g0), .gp(gp0), .gg(gg0));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: each slice is a one-bit addition a+b+cin; P means the two
  // operand bits differ, G means both are set. Group G is the carry out of the
  // unsigned sum a+b, group P means a+b is all ones (a carry-in would pass through).
  function automatic logic [31:0] ref_slices(input int w, input logic [7:0] a,
                                             input logic [7:0] b, input logic [7:0] c);
    // returns {g, p, cout, s} packed as 4 bytes
    logic [7:0] rs, rc, rp, rg;
    int sum;
    rs = '0; rc = '0; rp = '0; rg = '0;
    for (int i = 0; i < w; i++) begin
      sum   = int'(a[i]) + int'(b[i]) + int'(c[i]);
      rs[i] = (sum % 2) == 1;
      rc[i] = sum >= 2;
      rp[i] = (int'(a[i]) + int'(b[i])) == 1;
      rg[i] = (int'(a[i]) + int'(b[i])) == 2;
    end
    return {rg, rp, rc, rs};
  endfunction

  function automatic logic ref_gg(input int w, input logic [7:0] a, input logic [7:0] b);
    int sum;
    sum = int'(a) + int'(b);
    return ((sum >> w) & 1) == 1;
  endfunction

  function automatic logic ref_gp(input int w, input logic [7:0] a, input logic [7:0] b);
    int sum;
    sum = int'(a) + int'(b);
    return sum == ((1 << w) - 1);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    vld1 = 0; cin1 = 0; a1 = 0; b1 = 0;
    vld4 = 0; cin4 = 0; a4 = 0; b4 = 0;
    vld8 = 0; cin8 = 0; a8 = 0; b8 = 0;
    vld0 = 0; cin0 = 0; a0 = 0; b0 = 0;
    #2 rst_n = 1'b0;
    repeat (3) tick();
    total++;
    if ({ov1, s1, co1, p1, g1, gp1, gg1} !== 7'b0) begin
      bad++;
      $display("FAIL reset_w1: got %b want 0000000", {ov1, s1, co1, p1, g1, gp1, gg1});
    end
    total++;
    if ({ov4, s4, co4, p4, g4, gp4, gg4} !== 19'b0) begin
      bad++;
      $display("FAIL reset_w4: got %b want all zero", {ov4, s4, co4, p4, g4, gp4, gg4});
    end
    total++;
    if ({ov8, s8, co8, p8, g8, gp8, gg8} !== 35'b0) begin
      bad++;
      $display("FAIL reset_w8: got %b want all zero", {ov8, s8, co8, p8, g8, gp8, gg8});
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_truth_w1();
    logic [2:0]  v;
    logic [31:0] r;
    for (int k = 0; k < 8; k++) begin
      v = 3'(k);
      cin1 = v[2]; a1 = v[1]; b1 = v[0]; vld1 = 1'b1;
      r = ref_slices(1, {7'b0, v[1]}, {7'b0, v[0]}, {7'b0, v[2]});
      tick();
      total++;
      if ({ov1, s1, co1, p1, g1, gp1, gg1} !==
          {1'b1, r[0], r[8], r[16], r[24], r[16], r[24]}) begin
        bad++;
        $display("FAIL truth_w1 cin/a/b=%b: got ov,s,co,p,g,gp,gg=%b want %b", v,
                 {ov1, s1, co1, p1, g1, gp1, gg1},
                 {1'b1, r[0], r[8], r[16], r[24], r[16], r[24]});
      end
    end
    vld1 = 1'b0;
    tick();
  endtask

  // Two passes per case: first get P/G, build slice carries with lookahead,
  // then feed them back and check the full sum against a+b+cin0.
  task automatic test_cla_w4();
    logic [3:0] c;
    logic       cl;
    int         want, got;
    for (int cz = 0; cz < 2; cz++) begin
      for (int av = 0; av < 16; av++) begin
        for (int bv = 0; bv < 16; bv++) begin
          a4 = 4'(av); b4 = 4'(bv); cin4 = 4'b0; vld4 = 1'b1;
          tick();
          cl = (cz == 1);
          for (int i = 0; i < 4; i++) begin
            c[i] = cl;
            cl = g4[i] | (p4[i] & cl);
          end
          cin4 = c;
          tick();
          want = av + bv + cz;
          got  = int'({gg4 | (gp4 & (cz == 1)), s4});
          total++;
          if (got !== want || ov4 !== 1'b1) begin
            bad++;
            $display("FAIL cla_w4 %0d+%0d+%0d: got %0d ov=%b want %0d ov=1",
                     av, bv, cz, got, ov4, want);
          end
        end
      end
    end
    vld4 = 1'b0;
    tick();
  endtask

  task automatic test_hold();
    a4 = 4'b0110; b4 = 4'b0011; cin4 = 4'b0000; vld4 = 1'b1;
    tick();
    total++;
    if ({ov4, s4, g4, p4} !== {1'b1, 4'b0101, 4'b0010, 4'b0101}) begin
      bad++;
      $display("FAIL hold_load: got ov,s,g,p=%b want 1_0101_0010_0101", {ov4, s4, g4, p4});
    end
    a4 = 4'b1111; b4 = 4'b1010; cin4 = 4'b1111; vld4 = 1'b0;
    tick();
    total++;
    if ({ov4, s4, g4, p4} !== {1'b0, 4'b0101, 4'b0010, 4'b0101}) begin
      bad++;
      $display("FAIL hold_keep: got ov,s,g,p=%b want 0_0101_0010_0101", {ov4, s4, g4, p4});
    end
    tick();
    total++;
    if ({ov4, s4, g4, p4, co4} !== {1'b0, 4'b0101, 4'b0010, 4'b0101, 4'b0010}) begin
      bad++;
      $display("FAIL hold_keep2: got ov,s,g,p,co=%b want 0_0101_0010_0101_0010",
               {ov4, s4, g4, p4, co4});
    end
  endtask

  // Random valid/data stream on the 8-slice instance, model tracks held values.
  task automatic test_random_w8(input int n);
    logic [31:0] r, er;
    logic        egp, egg, eov;
    er = '0; egp = 0; egg = 0; eov = 0;
    for (int k = 0; k < n; k++) begin
      a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 8'($urandom);
      vld8 = ($urandom_range(3) != 0);
      if (k % 17 == 0) b8 = ~a8;
      r = ref_slices(8, a8, b8, cin8);
      if (vld8) begin
        er = r; egp = ref_gp(8, a8, b8); egg = ref_gg(8, a8, b8);
      end
      eov = vld8;
      tick();
      total++;
      if ({ov8, g8, p8, co8, s8, gp8, gg8} !== {eov, er, egp, egg}) begin
        bad++;
        $display("FAIL random_w8 #%0d: got ov,g,p,co,s,gp,gg=%b want %b", k,
                 {ov8, g8, p8, co8, s8, gp8, gg8}, {eov, er, egp, egg});
      end
    end
    vld8 = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    logic [31:0] r;
    for (int k = 0; k < 20; k++) begin
      a4 = 4'($urandom); b4 = 4'($urandom); cin4 = 4'($urandom); vld4 = 1'b1;
      r = ref_slices(4, {4'b0, a4}, {4'b0, b4}, {4'b0, cin4});
      tick();
      total++;
      if ({ov4, g4, p4, co4, s4, gp4, gg4} !==
          {1'b1, r[27:24], r[19:16], r[11:8], r[3:0],
           ref_gp(4, {4'b0, a4}, {4'b0, b4}), ref_gg(4, {4'b0, a4}, {4'b0, b4})}) begin
        bad++;
        $display("FAIL b2b_w4 #%0d a=%b b=%b c=%b: got %b", k, a4, b4, cin4,
                 {ov4, g4, p4, co4, s4, gp4, gg4});
      end
    end
    vld4 = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    a4 = 4'b1011; b4 = 4'b0110; cin4 = 4'b1101; vld4 = 1'b1;
    a1 = 1; b1 = 1; cin1 = 1; vld1 = 1'b1;
    tick();
    total++;
    if (ov4 !== 1'b1 || ov1 !== 1'b1) begin
      bad++;
      $display("FAIL rstmid_pre: got ov4=%b ov1=%b want 1 1", ov4, ov1);
    end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({ov4, s4, co4, p4, g4, gp4, gg4} !== 19'b0 ||
        {ov1, s1, co1, p1, g1, gp1, gg1} !== 7'b0) begin
      bad++;
      $display("FAIL rstmid_async: got w4=%b w1=%b want all zero",
               {ov4, s4, co4, p4, g4, gp4, gg4}, {ov1, s1, co1, p1, g1, gp1, gg1});
    end
    @(negedge clk);
    rst_n = 1'b1;
    a4 = 4'b1001; b4 = 4'b0101; cin4 = 4'b0011; vld4 = 1'b1;
    vld1 = 1'b0;
    tick();
    total++;
    if ({ov4, s4, co4, p4, g4, gp4, gg4} !==
        {1'b1, 4'b1111, 4'b0001, 4'b1100, 4'b0001, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL rstmid_first: got %b want 1_1111_0001_1100_0001_0_0",
               {ov4, s4, co4, p4, g4, gp4, gg4});
    end
    vld4 = 1'b0;
    tick();
  endtask

  task automatic test_comb();
    a0 = 1; b0 = 1; cin0 = 1; vld0 = 1;
    #1;
    total++;
    if ({ov0, s0, co0, p0, g0, gp0, gg0} !== 7'b1110101) begin
      bad++;
      $display("FAIL comb_111: got %b want 1110101", {ov0, s0, co0, p0, g0, gp0, gg0});
    end
    a0 = 0; b0 = 1; cin0 = 0; vld0 = 0;
    #1;
    total++;
    if ({ov0, s0, co0, p0, g0, gp0, gg0} !== 7'b0101010) begin
      bad++;
      $display("FAIL comb_010: got %b want 0101010", {ov0, s0, co0, p0, g0, gp0, gg0});
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_truth_w1();
    test_cla_w4();
    test_hold();
    test_back_to_back();
    test_random_w8(200);
    test_reset_mid();
    test_comb();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
